// File: rtl/bsg_skid_buffer_reset.sv
// Two-entry skid buffer (head/tail) with ready/valid upstream and valid/yumi downstream.
// Optional BSG_SKID_BUFFER_OCCUPANCY_EN adds a registered 2-bit occupancy output count_o.
module bsg_skid_buffer_reset #(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
`ifdef BSG_SKID_BUFFER_OCCUPANCY_EN
    ,
    output logic [1:0]         count_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [width_p-1:0] head_q, head_d;
    logic [width_p-1:0] tail_q, tail_d;
    logic               live_q, live_d;
    logic               enq, deq;

    // live_q holds ready_o low until the first clock edge after reset releases
    assign ready_o = live_q & (state_q != ST_TWO);
    assign v_o     = (state_q != ST_EMPTY);
    assign data_o  = head_q;

    always_comb begin
        enq     = v_i & ready_o;
        deq     = yumi_i & v_o;
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        live_d  = 1'b1;
        case (state_q)
            ST_EMPTY: begin
                if (enq) begin
                    head_d  = data_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({enq, deq})
                    2'b10: begin
                        tail_d  = data_i;
                        state_d = ST_TWO;
                    end
                    2'b01:   state_d = ST_EMPTY;
                    2'b11:   head_d  = data_i;
                    default: state_d = ST_ONE;
                endcase
            end
            ST_TWO: begin
                if (deq) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            live_q  <= live_d;
        end
    end

`ifdef BSG_SKID_BUFFER_OCCUPANCY_EN
    logic [1:0] count_q, count_d;

    always_comb begin
        count_d = 2'd0;
        case (state_d)
            ST_ONE:  count_d = 2'd1;
            ST_TWO:  count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
`endif

endmodule

// File: tb/tb_bsg_skid_buffer_reset.sv
// Directed and scoreboarded bench for bsg_skid_buffer_reset (64-bit payload).
// Honours BSG_SKID_BUFFER_OCCUPANCY_EN to also check count_o.
module tb_bsg_skid_buffer_reset;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_i;
    logic        yumi_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic        v_o;
    logic [63:0] data_o;
`ifdef BSG_SKID_BUFFER_OCCUPANCY_EN
    logic [1:0]  count_o;
`endif

    bsg_skid_buffer_reset #(.width_p(64)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i)
`ifdef BSG_SKID_BUFFER_OCCUPANCY_EN
        ,
        .count_o   (count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        y;
        logic [63:0] d;
        logic        ev;
        logic        er;
        logic [63:0] ed;
        logic [1:0]  ec;
    } vec_t;

    vec_t        tbl [12];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_count(input string name, input logic [1:0] exp);
`ifdef BSG_SKID_BUFFER_OCCUPANCY_EN
        check(name, {62'd0, count_o}, {62'd0, exp});
`else
        if (exp > 2'd2) $display("bad expected count in %s", name);
`endif
    endtask

    task automatic cycle(input logic v, input logic y, input logic [63:0] d);
        @(negedge clk);
        v_i = v; yumi_i = y; data_i = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic enq, deq, r_exp;
        rst_n = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;

        //            v     y     d                       ev    er    ed                      ec
        tbl[0]  = '{1'b1, 1'b0, 64'hDEADBEEF_00000001, 1'b1, 1'b1, 64'hDEADBEEF_00000001, 2'd1};
        tbl[1]  = '{1'b1, 1'b0, 64'h2,                 1'b1, 1'b0, 64'hDEADBEEF_00000001, 2'd2};
        tbl[2]  = '{1'b1, 1'b0, 64'h3,                 1'b1, 1'b0, 64'hDEADBEEF_00000001, 2'd2};
        tbl[3]  = '{1'b0, 1'b1, 64'h0,                 1'b1, 1'b1, 64'h2,                 2'd1};
        tbl[4]  = '{1'b0, 1'b1, 64'h0,                 1'b0, 1'b1, 64'h2,                 2'd0};
        tbl[5]  = '{1'b0, 1'b1, 64'h0,                 1'b0, 1'b1, 64'h2,                 2'd0};
        tbl[6]  = '{1'b1, 1'b1, 64'h55,                1'b1, 1'b1, 64'h55,                2'd1};
        tbl[7]  = '{1'b1, 1'b1, 64'h66,                1'b1, 1'b1, 64'h66,                2'd1};
        tbl[8]  = '{1'b1, 1'b0, 64'h77,                1'b1, 1'b0, 64'h66,                2'd2};
        tbl[9]  = '{1'b1, 1'b1, 64'h88,                1'b1, 1'b1, 64'h77,                2'd1};
        tbl[10] = '{1'b0, 1'b0, 64'h99,                1'b1, 1'b1, 64'h77,                2'd1};
        tbl[11] = '{1'b0, 1'b1, 64'h0,                 1'b0, 1'b1, 64'h77,                2'd0};

        // reset held, then released with a word already offered
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_v_o", {63'd0, v_o}, 64'd0);
        check("rst_data_o", data_o, 64'd0);
        check("rst_ready_o", {63'd0, ready_o}, 64'd0);
        check_count("rst_count_o", 2'd0);
        v_i = 1'b1; data_i = 64'hBAD; rst_n = 1'b1;
        #1;
        check("post_rst_ready_pre_edge", {63'd0, ready_o}, 64'd0);
        @(posedge clk);
        #1;
        check("post_rst_ready_first_edge", {63'd0, ready_o}, 64'd1);
        check("post_rst_no_enq", {63'd0, v_o}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v, tbl[i].y, tbl[i].d);
            check($sformatf("vec%0d_v_o", i), {63'd0, v_o}, {63'd0, tbl[i].ev});
            check($sformatf("vec%0d_ready_o", i), {63'd0, ready_o}, {63'd0, tbl[i].er});
            check($sformatf("vec%0d_data_o", i), data_o, tbl[i].ed);
            check_count($sformatf("vec%0d_count_o", i), tbl[i].ec);
            $display("vec %0d: v_i=%0b yumi_i=%0b data_i=%h -> v_o=%0b ready_o=%0b data_o=%h",
                     i, tbl[i].v, tbl[i].y, tbl[i].d, v_o, ready_o, data_o);
        end

        // sustained stream: one word per cycle, state stays ONE
        cycle(1'b1, 1'b0, 64'd0);
        check("stream_first", data_o, 64'd0);
        for (int i = 1; i < 100; i++) begin
            cycle(1'b1, 1'b1, 64'(i));
            check($sformatf("stream%0d_data", i), data_o, 64'(i));
            check($sformatf("stream%0d_v", i), {63'd0, v_o}, 64'd1);
            check($sformatf("stream%0d_ready", i), {63'd0, ready_o}, 64'd1);
            check_count($sformatf("stream%0d_count", i), 2'd1);
        end
        cycle(1'b0, 1'b1, 64'd0);
        check("stream_drained", {63'd0, v_o}, 64'd0);
        $display("stream: 100 words passed through");

        // random traffic against a queue model
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            v_i = 1'($urandom_range(0, 1));
            yumi_i = 1'($urandom_range(0, 1));
            data_i = {$urandom, $urandom};
            r_exp = (q.size() < 2);
            #1;
            check("rnd_ready", {63'd0, ready_o}, {63'd0, r_exp});
            yumi_i = ~yumi_i;
            #1;
            check("rnd_ready_vs_yumi", {63'd0, ready_o}, {63'd0, r_exp});
            yumi_i = ~yumi_i;
            enq = v_i && (q.size() < 2);
            deq = yumi_i && (q.size() > 0);
            @(posedge clk);
            #1;
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(data_i);
            check("rnd_v_o", {63'd0, v_o}, {63'd0, (q.size() > 0)});
            check("rnd_ready_post", {63'd0, ready_o}, {63'd0, (q.size() < 2)});
            if (q.size() > 0) check("rnd_data_o", data_o, q[0]);
            check_count("rnd_count", 2'(q.size()));
        end
        $display("random: 10000 cycles, %0d words left in model", q.size());

        // asynchronous reset while holding two words
        cycle(1'b0, 1'b1, 64'd0);
        cycle(1'b0, 1'b1, 64'd0);
        cycle(1'b1, 1'b0, 64'hAAAA_0000_0000_000A);
        cycle(1'b1, 1'b0, 64'hBBBB_0000_0000_000B);
        check("two_ready", {63'd0, ready_o}, 64'd0);
        check("two_data", data_o, 64'hAAAA_0000_0000_000A);
        #2;
        v_i = 1'b0; yumi_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_v_o", {63'd0, v_o}, 64'd0);
        check("async_rst_data_o", data_o, 64'd0);
        check("async_rst_ready_o", {63'd0, ready_o}, 64'd0);
        check_count("async_rst_count", 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerst_ready", {63'd0, ready_o}, 64'd1);
        check("rerst_v_o", {63'd0, v_o}, 64'd0);
        cycle(1'b1, 1'b0, 64'hCCCC_0000_0000_000C);
        check("after_rst_data", data_o, 64'hCCCC_0000_0000_000C);
        check("after_rst_v_o", {63'd0, v_o}, 64'd1);
        cycle(1'b0, 1'b1, 64'd0);
        check("after_rst_empty", {63'd0, v_o}, 64'd0);
        $display("async reset: stored words discarded");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_skid_buffer_reset.md
BSG_SKID_BUFFER_RESET -- requirements
Module: bsg_skid_buffer_reset

Interface
REQ-001 The block SHALL have one parameter: width_p, default 64, payload width in bits.
REQ-002 The block SHALL have input clk_i, width 1: the single clock, all state updated on its rising edge.
REQ-003 The block SHALL have input reset_n_i, width 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have input v_i, width 1: upstream valid.
REQ-005 The block SHALL have input data_i, width width_p: upstream payload.
REQ-006 The block SHALL have output ready_o, width 1: block can accept a word this cycle.
REQ-007 The block SHALL have output v_o, width 1: downstream valid.
REQ-008 The block SHALL have output data_o, width width_p: downstream payload (head entry).
REQ-009 The block SHALL have input yumi_i, width 1: downstream consumes the head this cycle; legal only while v_o=1.

Function
REQ-010 The block SHALL store two entries (head, tail) with state EMPTY, ONE or TWO.
REQ-011 Enqueue SHALL occur on a rising edge where v_i=1 and ready_o=1; dequeue SHALL occur where yumi_i=1 and v_o=1.
REQ-012 ready_o SHALL be 1 in EMPTY and ONE, 0 in TWO; it SHALL be driven from state only, with no combinational path from yumi_i or v_i.
REQ-013 v_o SHALL be 1 in ONE and TWO, 0 in EMPTY; it SHALL be driven from state only.
REQ-014 EMPTY, enqueue: write head, go to ONE; data_o equals the written word on the next cycle (1-cycle latency).
REQ-015 ONE, enqueue only: write tail, go to TWO.
REQ-016 ONE, dequeue only: go to EMPTY; head contents are don't-care afterwards but SHALL keep the last value.
REQ-017 ONE, enqueue and dequeue together: write the new word into head, stay in ONE.
REQ-018 TWO, dequeue: move tail to head, go to ONE; no enqueue can occur because ready_o=0.
REQ-019 Order SHALL be strict FIFO: no word is dropped, duplicated or reordered.
REQ-020 In every state, v_i=1 with ready_o=0 SHALL leave all storage unchanged.
REQ-021 yumi_i=1 with v_o=0 is illegal; the block SHALL ignore it and leave state unchanged.
REQ-022 Sustained v_i=1 and yumi_i=1 from ONE SHALL give one word per cycle throughput.

Reset
REQ-023 While reset_n_i=0, state SHALL be EMPTY, head and tail SHALL be all zeros, ready_o=0, v_o=0 and data_o=0, with outputs changing immediately and independently of clk_i.
REQ-024 Reset asserted mid-operation SHALL discard all stored words.
REQ-025 ready_o SHALL rise on the first rising clk_i edge after reset_n_i deasserts; no enqueue SHALL be accepted on that edge.

Configuration
REQ-026 The macro BSG_SKID_BUFFER_OCCUPANCY_EN, when defined, SHALL add output count_o, width 2, giving occupancy: 0 for EMPTY, 1 for ONE, 2 for TWO.
REQ-027 count_o SHALL be registered and SHALL reset to 0.
REQ-028 Without BSG_SKID_BUFFER_OCCUPANCY_EN, count_o SHALL be absent, and all other behaviour SHALL be identical bit-for-bit.

Verification
REQ-029 Scenario 1: hold reset_n_i=0, then deassert -> v_o=0, data_o=0, ready_o=0 until the first rising edge, then ready_o=1.
REQ-030 Scenario 2: enqueue 0xDEADBEEF_00000001 then 0x2 with yumi_i=0 -> v_o=1, data_o=0xDEADBEEF_00000001, ready_o=0 (count_o=2 if enabled).
REQ-031 Scenario 3: from TWO, pulse yumi_i for two cycles -> data_o goes 0xDEADBEEF_00000001, then 0x2, then v_o=0; ready_o returns to 1 after the first dequeue.
REQ-032 Scenario 4: stream 0..99 with v_i=1 and yumi_i=1 continuously -> outputs 0..99 in order, one per cycle, state stays ONE.
REQ-033 Scenario 5: random v_i/yumi_i at 50% for 10,000 cycles -> scoreboard matches exactly; ready_o=0 is never observed combinationally dependent on yumi_i.
REQ-034 Scenario 6: assert reset_n_i=0 asynchronously between clock edges while in TWO -> v_o=0 and data_o=0 immediately; the next accepted word is the first one seen after reset.
